// File: rtl/clk_enable_sched_if.sv
// Config handshake bundle for clk_enable_sched.
// Master drives a channel write; slave answers with cfg_ready.
interface clk_enable_sched_if #(
  parameter int NUM_CH   = 2,
  parameter int ACC_BITS = 24,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_ch;
  logic [ACC_BITS-1:0] cfg_inc;
  logic                cfg_run;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_inc,
    output cfg_run,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_inc,
    input  cfg_run,
    output cfg_ready
  );
endinterface

// File: rtl/clk_enable_sched.sv
// Multi-channel NCO clock-enable scheduler; ratio/run changes land at wrap.
// Define CLKSCHED_SQUARE_OUT_EN to add the ch_sq square-wave outputs.
module clk_enable_sched #(
  parameter int NUM_CH   = 2,
  parameter int ACC_BITS = 24
) (
  input  logic                clk_src,
  input  logic                rst_n,
  clk_enable_sched_if.slave   cfg,
  output logic [NUM_CH-1:0]   ch_en,
`ifdef CLKSCHED_SQUARE_OUT_EN
  output logic [NUM_CH-1:0]   ch_sq,
`endif
  output logic [NUM_CH-1:0]   ch_active
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } st_e;

  st_e                 st_q   [NUM_CH];
  logic [ACC_BITS-1:0] acc_q  [NUM_CH];
  logic [ACC_BITS-1:0] inc_q  [NUM_CH];
  logic [ACC_BITS-1:0] pinc_q [NUM_CH];
  logic [NUM_CH-1:0]   prun_q;
  logic [NUM_CH-1:0]   pval_q;
  logic [NUM_CH-1:0]   carry_q;
  logic [NUM_CH-1:0]   en_q;

  logic [ACC_BITS:0]   sum    [NUM_CH];
  logic [NUM_CH-1:0]   hit;
  logic                rdy;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i] = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
    end
  end

  // Unmapped channel numbers read as ready and are silently dropped.
  always_comb begin
    hit = '0;
    rdy = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) begin
        rdy    = !pval_q[i];
        hit[i] = cfg.cfg_valid & !pval_q[i];
      end
    end
  end

  assign cfg.cfg_ready = rdy;

  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]   <= IDLE;
        acc_q[i]  <= '0;
        inc_q[i]  <= '0;
        pinc_q[i] <= '0;
      end
      prun_q  <= '0;
      pval_q  <= '0;
      carry_q <= '0;
      en_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        en_q[i] <= 1'b0;
        unique case (st_q[i])
          IDLE: begin
            carry_q[i] <= 1'b0;
            if (hit[i]) begin
              inc_q[i] <= cfg.cfg_inc;
              acc_q[i] <= '0;
              if (cfg.cfg_run) st_q[i] <= RUN;
            end
          end
          RUN, STOP: begin
            acc_q[i]   <= sum[i][ACC_BITS-1:0];
            carry_q[i] <= sum[i][ACC_BITS];
            en_q[i]    <= carry_q[i];
            // inc==0 never wraps, so pending work applies right away.
            if (pval_q[i] &&
                (carry_q[i] || inc_q[i] == '0)) begin
              inc_q[i]  <= pinc_q[i];
              pval_q[i] <= 1'b0;
              if (prun_q[i]) begin
                st_q[i] <= RUN;
              end else begin
                st_q[i]    <= IDLE;
                acc_q[i]   <= '0;
                carry_q[i] <= 1'b0;
              end
            end else if (hit[i]) begin
              pinc_q[i] <= cfg.cfg_inc;
              prun_q[i] <= cfg.cfg_run;
              pval_q[i] <= 1'b1;
              st_q[i]   <= cfg.cfg_run ? RUN : STOP;
            end
          end
          default: st_q[i] <= IDLE;
        endcase
      end
    end
  end

  assign ch_en = en_q;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_active[i] = (st_q[i] != IDLE);
    end
  end

`ifdef CLKSCHED_SQUARE_OUT_EN
  logic [NUM_CH-1:0] sq_q;

  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      sq_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        sq_q[i] <= (st_q[i] != IDLE) &&
                   acc_q[i][ACC_BITS-1];
      end
    end
  end

  assign ch_sq = sq_q;
`endif

endmodule

// File: tb/tb_clk_enable_sched.sv
// Directed bench for clk_enable_sched.
// Strobe times are queued when a config is issued and popped on each ch_en.
module tb_clk_enable_sched;

  localparam int NUM_CH   = 2;
  localparam int ACC_BITS = 24;

  logic clk_src = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_src = ~clk_src;

  clk_enable_sched_if #(
    .NUM_CH(NUM_CH), .ACC_BITS(ACC_BITS)
  ) cfg ();

  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] ch_active;
`ifdef CLKSCHED_SQUARE_OUT_EN
  logic [NUM_CH-1:0] ch_sq;
`endif

  clk_enable_sched #(
    .NUM_CH(NUM_CH), .ACC_BITS(ACC_BITS)
  ) dut (
    .clk_src   (clk_src),
    .rst_n     (rst_n),
    .cfg       (cfg),
    .ch_en     (ch_en),
`ifdef CLKSCHED_SQUARE_OUT_EN
    .ch_sq     (ch_sq),
`endif
    .ch_active (ch_active)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int q0[$];
  int q1[$];
  bit sb_on  = 1'b1;
  int cnt    = 0;
  int last   = -1;
  int gmin   = 1000;
  int gmax   = 0;
  int win_lo = 32'h7fff_ffff;
  int win_hi = 0;

  always @(posedge clk_src) cyc <= cyc + 1;

  task automatic pop0();
    int e;
    total++;
    assert (q0.size() != 0) else begin
      bad++;
      $error("FAIL strobe0_extra got=cyc%0d exp=none", cyc);
    end
    if (q0.size() != 0) begin
      e = q0.pop_front();
      total++;
      assert (cyc === e) else begin
        bad++;
        $error("FAIL strobe0_time got=%0d exp=%0d", cyc, e);
      end
    end
  endtask

  task automatic pop1();
    int e;
    total++;
    assert (q1.size() != 0) else begin
      bad++;
      $error("FAIL strobe1_extra got=cyc%0d exp=none", cyc);
    end
    if (q1.size() != 0) begin
      e = q1.pop_front();
      total++;
      assert (cyc === e) else begin
        bad++;
        $error("FAIL strobe1_time got=%0d exp=%0d", cyc, e);
      end
    end
  endtask

  always @(negedge clk_src) begin
    if (ch_en[0]) begin
      if (sb_on) begin
        pop0();
      end else if (cyc >= win_lo && cyc <= win_hi) begin
        cnt++;
        if (last >= 0) begin
          if (cyc - last < gmin) gmin = cyc - last;
          if (cyc - last > gmax) gmax = cyc - last;
        end
        last = cyc;
      end
    end
    if (ch_en[1]) pop1();
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk_src);
  endtask

  task automatic wr(input int ch,
                    input logic [ACC_BITS-1:0] inc,
                    input logic run,
                    output int edge_no);
    int n = 0;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = 1'(ch);
    cfg.cfg_inc   = inc;
    cfg.cfg_run   = run;
    #1;
    while (!cfg.cfg_ready && n < 100) begin
      @(negedge clk_src);
      #1;
      n++;
    end
    total++;
    assert (cfg.cfg_ready === 1'b1) else begin
      bad++;
      $error("FAIL wr_timeout got=%0d exp=1", cfg.cfg_ready);
    end
    @(posedge clk_src);
    #1;
    edge_no = cyc;
    cfg.cfg_valid = 1'b0;
  endtask

  initial begin
    int a, b, b2, s, r, x;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_ch    = '0;
    cfg.cfg_inc   = '0;
    cfg.cfg_run   = 1'b0;
    repeat (3) @(negedge clk_src);
    chk("rst_en", 32'(ch_en), 0);
    chk("rst_act", 32'(ch_active), 0);
    chk("rst_rdy", 32'(cfg.cfg_ready), 1);
    rst_n = 1'b1;
    @(negedge clk_src);

    // 0x400000: first strobe 5 after accept, then every 4
    wr(0, 24'h400000, 1'b1, a);
    for (int k = 0; k < 5; k++) q0.push_back(a + 5 + 4 * k);
    wait_until(a + 2);
    chk("run_act", 32'(ch_active[0]), 1);

    // rate change to 0x800000 plus a stalled second write
    wait_until(a + 17);
    wr(0, 24'h800000, 1'b1, b);
    chk("rate_acc", b - a, 18);
    chk("pend_rdy", 32'(cfg.cfg_ready), 0);
    wr(0, 24'h800000, 1'b1, b2);
    chk("stall_acc", b2 - a, 22);
    for (int k = 0; k < 5; k++) q0.push_back(a + 24 + 2 * k);

    // stop: one final strobe, active drops with it
    wait_until(a + 30);
    wr(0, 24'h800000, 1'b0, s);
    chk("stop_acc", s - a, 31);
    @(negedge clk_src);
    chk("stopping_act", 32'(ch_active[0]), 1);
    wait_until(a + 32);
    chk("stop_act", 32'(ch_active[0]), 0);
    chk("stop_en", 32'(ch_en[0]), 1);
    wait_until(a + 50);
    chk("stop_quiet", q0.size(), 0);

    // restart from acc=0
    wr(0, 24'h400000, 1'b1, r);
    q0.push_back(r + 5);
    q0.push_back(r + 9);
    q0.push_back(r + 13);
    wait_until(r + 10);
    wr(0, 24'h400000, 1'b0, x);
    wait_until(r + 20);
    chk("restart_act", 32'(ch_active[0]), 0);
    chk("restart_q", q0.size(), 0);

    // 0x555555 over 300 adds
    sb_on = 1'b0;
    wr(0, 24'h555555, 1'b1, r);
    cnt = 0; last = -1; win_lo = r + 2; win_hi = r + 301;
    wait_until(r + 305);
    chk("cnt_555555", cnt, 99);
    wr(0, 24'h555555, 1'b0, x);
    repeat (10) @(negedge clk_src);
    chk("idle_555555", 32'(ch_active[0]), 0);

    // 0x471C71 over 3600 adds, gaps 3 or 4
    wr(0, 24'h471C71, 1'b1, r);
    cnt = 0; last = -1; gmin = 1000; gmax = 0;
    win_lo = r + 2; win_hi = r + 3601;
    wait_until(r + 3605);
    chk("cnt_471c71", cnt, 999);
    chk("gap_min", gmin, 3);
    chk("gap_max", gmax, 4);

    // async reset between edges while running
    @(posedge clk_src);
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_en", 32'(ch_en), 0);
    chk("mrst_act", 32'(ch_active), 0);
    chk("mrst_rdy", 32'(cfg.cfg_ready), 1);
    @(negedge clk_src);
    rst_n = 1'b1;
    sb_on = 1'b1;
    @(negedge clk_src);

    // ch1 inc=0: never strobes, stop lands next cycle
    wr(1, 24'h000000, 1'b1, b);
    wr(1, 24'h000000, 1'b0, b2);
    chk("z_acc", b2 - b, 1);
    @(negedge clk_src);
    chk("z_act_run", 32'(ch_active[1]), 1);
    @(negedge clk_src);
    chk("z_act_idle", 32'(ch_active[1]), 0);
    repeat (10) @(negedge clk_src);
    chk("end_q0", q0.size(), 0);
    chk("end_q1", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_enable_sched.md
Name: clk_enable_sched

Overview:
- Multi-channel fractional clock-enable scheduler on the single fast clock, `clk_src` (e.g. 135 MHz).
- Each channel is a programmable phase accumulator (NCO). It emits a one-cycle enable strobe at the average rate f_clk*inc/2^ACC_BITS.
- Downstream video/audio/CPU-timing logic shares one clock domain instead of using divided clocks.
- Runtime ratio changes and start/stop are sequenced glitch-free: they take effect only at accumulator wrap.

Parameters:
NUM_CH, 2, number of independent enable channels (1..8)
ACC_BITS, 24, phase accumulator / increment width

Ports:
clk_src  in  1  fast source clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  config request valid
cfg_ready  out  1  config can be accepted for channel cfg_ch
cfg_ch  in  max(1,$clog2(NUM_CH))  target channel
cfg_inc  in  ACC_BITS  new phase increment
cfg_run  in  1  1 = run, 0 = stop
ch_en  out  NUM_CH  per-channel one-cycle enable strobe
ch_active  out  NUM_CH  channel in RUN or STOPPING state

Behaviour:
- Reset, asynchronous, any time including mid-operation:
  - All acc=0, inc=0, pending cleared, all channels IDLE.
  - ch_en=0, ch_active=0, cfg_ready=1.
- Per-channel state: acc[ACC_BITS], inc, pend_inc, pend_run, pend_valid, state in {IDLE, RUN, STOPPING}.
- Carry: in RUN/STOPPING, each cycle {carry, acc} <= acc + inc, ACC_BITS+1-bit add, wraps mod 2^ACC_BITS.
- Strobe: ch_en[i] is registered and asserted on the cycle after the carry cycle. Latency from carry to strobe is 1 cycle; it is never wider than 1 cycle.
- cfg_ready is combinational: !pend_valid of channel cfg_ch. It is 1 when cfg_ch >= NUM_CH; such a transfer is accepted and ignored.
- Transfer occurs when cfg_valid & cfg_ready.
- IDLE accept:
  - inc <= cfg_inc, acc <= 0.
  - cfg_run=1 → RUN; first add happens the following cycle.
  - cfg_run=0 → stays IDLE with inc updated.
- RUN/STOPPING accept:
  - Latch pend_inc/pend_run and set pend_valid.
  - At the next carry cycle:
    - That cycle's add uses the old inc.
    - inc <= pend_inc, pend_valid cleared.
    - pend_run=0 → STOPPING becomes IDLE (see below); pend_run=1 → RUN, which cancels a stop.
- Stop: a pending run=0 is applied at the next carry.
  - The strobe for that carry is still emitted.
  - Then state → IDLE, acc <= 0, ch_active deasserts the same cycle the final strobe is driven.
- Special case, inc=0 in RUN: no carry ever occurs.
  - A pending config is applied immediately, the cycle after accept, with no strobe.
- Accept and carry in the same cycle, no pending: the config goes to pending. It is applied at the following carry, not the current one.
- inc=2^ACC_BITS-1 gives a strobe on all but one cycle per 2^ACC_BITS. There is no saturation.
- Channels are fully independent: one cfg transfer per cycle, no cross-channel ordering.

Optional Feature:
- Macro: CLKSCHED_SQUARE_OUT_EN.
- When defined:
  - Adds output port ch_sq[NUM_CH], registered: ch_sq[i] = acc MSB of channel i.
  - This gives an approximately 50% duty square wave at the strobe rate, for driving pins or legacy divided-clock consumers.
  - ch_sq is 0 in IDLE and at reset.
- When undefined: the port and its registers do not exist, and behaviour is otherwise identical.

Test Plan:
- ACC_BITS=24, ch0 cfg inc=0x400000 run=1 → ch_en[0] strobes exactly every 4 cycles. The first strobe is 5 cycles after accept (4 adds + 1 register).
- ch0 inc=0x555555 run=1, count strobes over 300 cycles after the first add → exactly 99 strobes.
- ch0 inc=0x471C71 (135/3.6 ≈ 37.5 MHz), count over 3600 cycles → 999 strobes, with gaps only 3 or 4 cycles.
- ch0 running at 0x400000, write inc=0x800000:
  - cfg_ready stays low until the next carry.
  - Following strobe intervals are 2 cycles.
  - A second write during pending is stalled.
- ch0 running, write run=0 → one more strobe, then ch_active[0]=0 and no further strobes. A later run=1 restarts from acc=0 (5-cycle first strobe at 0x400000).
- Reset mid-run:
  - Assert rst_n=0 asynchronously between edges → ch_en/ch_active drop immediately, cfg_ready=1.
  - Then ch1 config with inc=0 run=1, followed by run=0 → ch1 returns to IDLE 1 cycle after accept, with no strobe.
